// File: rtl/controle_placar_pkg.sv
// Shared types and constants for the two-team scoreboard controller.
package controle_placar_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    ATUALIZA = 2'd2,
    ALARME   = 2'd3
  } estado_t;

  localparam logic [6:0] MAX_PLACAR = 7'd99;
  localparam logic [1:0] PTS_A      = 2'd1;
  localparam logic [1:0] PTS_B      = 2'd2;
  localparam logic [1:0] PTS_C      = 2'd3;

endpackage

// File: rtl/controle_placar_detector_borda.sv
// 3-bit rising-edge detector; stays disarmed for the first cycle after reset
// so a button already held during reset release is not seen as a press.
module detector_borda (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sinal,
  output logic [2:0] borda
);

  logic [2:0] anterior_r;
  logic       armado_r;

  // previous-value register and post-reset arming flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anterior_r <= 3'b000;
      armado_r   <= 1'b0;
    end else begin
      anterior_r <= sinal;
      armado_r   <= 1'b1;
    end
  end

  assign borda = sinal & ~anterior_r & {3{armado_r}};

endmodule

// File: rtl/controle_placar.sv
// Two-team scoreboard: button presses add/subtract 1..3 points through a
// CALC/ATUALIZA pipeline; invalid operations sound a timed buzzer instead.
module controle_placar
  import controle_placar_pkg::*;
#(
  parameter int BUZZER_CICLOS = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  input  logic       chave_sub,
  input  logic       mudar_time,
  input  logic       zerar,
  output logic [6:0] placar_time0,
  output logic [6:0] placar_time1,
  output logic       buzzer,
  output logic       led,
  output logic       ocupado
);

  localparam int CW = $clog2(BUZZER_CICLOS + 1);

  estado_t       estado_r, estado_s;
  logic [CW-1:0] cont_r, cont_s;
  logic [2:0]    bordas_s;
  logic [6:0]    placar0_r, placar1_r, resultado_r;
  logic [1:0]    pts_r, pts_s;
  logic          sub_r, time_r, buzzer_r, led_r;
  logic          req_s, multi_s, valido_s;
  logic [7:0]    base_s, calc_s;

  detector_borda u_borda (
    .clk   (clk),
    .rst_n (rst_n),
    .sinal ({btn_c, btn_b, btn_a}),
    .borda (bordas_s)
  );

  assign req_s   = |bordas_s;
  assign multi_s = (bordas_s[0] & bordas_s[1]) | (bordas_s[0] & bordas_s[2]) |
                   (bordas_s[1] & bordas_s[2]);

  // point value of a single accepted edge
  always_comb begin
    pts_s = 2'd0;
    case (bordas_s)
      3'b001:  pts_s = PTS_A;
      3'b010:  pts_s = PTS_B;
      3'b100:  pts_s = PTS_C;
      default: pts_s = 2'd0;
    endcase
  end

  // Borrow shows up in bit 7 because scores never exceed 99.
  assign base_s   = {1'b0, (time_r ? placar1_r : placar0_r)};
  assign calc_s   = sub_r ? (base_s - {6'd0, pts_r}) : (base_s + {6'd0, pts_r});
  assign valido_s = sub_r ? ~calc_s[7] : (calc_s <= {1'b0, MAX_PLACAR});

  // next-state and alarm counter
  always_comb begin
    estado_s = estado_r;
    cont_s   = cont_r;
    if (zerar) begin
      estado_s = IDLE;
      cont_s   = {CW{1'b0}};
    end else begin
      case (estado_r)
        IDLE: begin
          if (req_s && multi_s) begin
            estado_s = ALARME;
            cont_s   = CW'(BUZZER_CICLOS);
          end else if (req_s) begin
            estado_s = CALC;
          end else begin
            estado_s = IDLE;
          end
        end
        CALC: begin
          if (valido_s) begin
            estado_s = ATUALIZA;
          end else begin
            estado_s = ALARME;
            cont_s   = CW'(BUZZER_CICLOS);
          end
        end
        ATUALIZA: estado_s = IDLE;
        ALARME: begin
          if (cont_r <= CW'(1)) begin
            estado_s = IDLE;
            cont_s   = {CW{1'b0}};
          end else begin
            cont_s = cont_r - CW'(1);
          end
        end
        default: begin
          estado_s = IDLE;
          cont_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // state, counter and buzzer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= IDLE;
      cont_r   <= {CW{1'b0}};
      buzzer_r <= 1'b0;
    end else begin
      estado_r <= estado_s;
      cont_r   <= cont_s;
      buzzer_r <= (estado_s == ALARME);
    end
  end

  // operation capture, result register and score update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      placar0_r   <= 7'd0;
      placar1_r   <= 7'd0;
      resultado_r <= 7'd0;
      pts_r       <= 2'd0;
      sub_r       <= 1'b0;
      time_r      <= 1'b0;
    end else if (zerar) begin
      placar0_r <= 7'd0;
      placar1_r <= 7'd0;
    end else begin
      if (estado_r == IDLE && req_s && !multi_s) begin
        pts_r  <= pts_s;
        sub_r  <= chave_sub;
        time_r <= mudar_time;
      end
      if (estado_r == CALC) begin
        resultado_r <= calc_s[6:0];
      end
      if (estado_r == ATUALIZA) begin
        if (time_r) begin
          placar1_r <= resultado_r;
        end else begin
          placar0_r <= resultado_r;
        end
      end
    end
  end

  // max-score indicator follows the scores by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 1'b0;
    end else begin
      led_r <= (placar0_r == MAX_PLACAR) | (placar1_r == MAX_PLACAR);
    end
  end

  assign placar_time0 = placar0_r;
  assign placar_time1 = placar1_r;
  assign buzzer       = buzzer_r;
  assign led          = led_r;
  assign ocupado      = (estado_r != IDLE);

endmodule

// File: tb/tb_controle_placar.sv
// Scoreboard bench for controle_placar with BUZZER_CICLOS=4.
module tb_controle_placar;

  logic       clk, rst_n, btn_a, btn_b, btn_c, chave_sub, mudar_time, zerar;
  logic [6:0] placar_time0, placar_time1;
  logic       buzzer, led, ocupado;

  int errors = 0;
  int checks = 0;
  int m0 = 0;
  int m1 = 0;

  typedef struct {
    int p0;
    int p1;
    int ocup;
    int bz;
  } exp_t;
  exp_t exp_q[$];

  controle_placar #(.BUZZER_CICLOS(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
    .chave_sub(chave_sub), .mudar_time(mudar_time), .zerar(zerar),
    .placar_time0(placar_time0), .placar_time1(placar_time1),
    .buzzer(buzzer), .led(led), .ocupado(ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_scores(input string nome, input int e0, input int e1);
    checks++;
    if (placar_time0 !== 7'(e0) || placar_time1 !== 7'(e1)) begin
      errors++;
      $display("FAIL %s: got %0d/%0d expected %0d/%0d", nome, placar_time0, placar_time1, e0, e1);
    end
  endtask

  // One button operation: model pushes expectation, DUT result pops and compares.
  task automatic op(input logic [2:0] mask, input logic sub, input logic team);
    int pts, cur, nv, cyc, bz;
    exp_t e;
    case (mask)
      3'b001:  pts = 1;
      3'b010:  pts = 2;
      3'b100:  pts = 3;
      default: pts = 0;
    endcase
    cur = team ? m1 : m0;
    nv  = sub ? cur - pts : cur + pts;
    if (pts == 0) begin
      e.ocup = 4; e.bz = 4;
    end else if (nv < 0 || nv > 99) begin
      e.ocup = 5; e.bz = 4;
    end else begin
      e.ocup = 2; e.bz = 0;
      if (team) m1 = nv; else m0 = nv;
    end
    e.p0 = m0; e.p1 = m1;
    exp_q.push_back(e);
    @(negedge clk);
    chave_sub = sub; mudar_time = team; {btn_c, btn_b, btn_a} = mask;
    @(negedge clk);
    {btn_c, btn_b, btn_a} = 3'b000; chave_sub = ~sub; mudar_time = ~team;
    cyc = 0; bz = 0;
    while (ocupado === 1'b1 && cyc < 20) begin
      if (buzzer === 1'b1) bz++;
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    checks++;
    if (cyc != e.ocup) begin
      errors++;
      $display("FAIL op_busy_cycles: got %0d expected %0d (mask %b)", cyc, e.ocup, mask);
    end
    checks++;
    if (bz != e.bz || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL op_buzzer: got %0d cycles (now %b) expected %0d cycles", bz, buzzer, e.bz);
    end
    check_scores("op_scores", e.p0, e.p1);
    @(negedge clk);
    checks++;
    if (led !== ((m0 == 99) || (m1 == 99))) begin
      errors++;
      $display("FAIL op_led: got %b expected %b", led, ((m0 == 99) || (m1 == 99)));
    end
  endtask

  task automatic do_zerar;
    @(negedge clk); zerar = 1'b1;
    @(negedge clk); zerar = 1'b0;
    m0 = 0; m1 = 0;
    check_scores("zerar_scores", 0, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
    chave_sub = 1'b0; mudar_time = 1'b0; zerar = 1'b0;
    repeat (3) @(negedge clk);
    check_scores("reset_scores", 0, 0);
    checks++;
    if ({buzzer, led, ocupado} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {buzzer, led, ocupado});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    op(3'b100, 1'b0, 1'b0);
    op(3'b001, 1'b0, 1'b1);
    op(3'b001, 1'b1, 1'b1);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 32; i++) op(3'b100, 1'b0, 1'b1);
    op(3'b010, 1'b0, 1'b1);
    op(3'b010, 1'b0, 1'b1);
  endtask

  task automatic test_boundary;
    for (int i = 0; i < 31; i++) op(3'b100, 1'b0, 1'b0);
    op(3'b001, 1'b0, 1'b0);
    op(3'b010, 1'b0, 1'b0);
    op(3'b001, 1'b1, 1'b0);
  endtask

  task automatic test_underflow;
    do_zerar();
    op(3'b001, 1'b0, 1'b0);
    op(3'b010, 1'b1, 1'b0);
    op(3'b101, 1'b0, 1'b0);
    op(3'b011, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    m0 = m0 + 1;
    e.p0 = m0; e.p1 = m1; e.ocup = 0; e.bz = 0;
    exp_q.push_back(e);
    @(negedge clk); chave_sub = 1'b0; mudar_time = 1'b0; {btn_c, btn_b, btn_a} = 3'b001;
    @(negedge clk); {btn_c, btn_b, btn_a} = 3'b010;
    @(negedge clk); {btn_c, btn_b, btn_a} = 3'b000;
    @(negedge clk);
    e = exp_q.pop_front();
    check_scores("ignore_first", e.p0, e.p1);
    repeat (4) @(negedge clk);
    check_scores("ignore_later", e.p0, e.p1);
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy: got %b expected 0", ocupado);
    end
  endtask

  task automatic test_zerar_alarme;
    @(negedge clk); {btn_c, btn_b, btn_a} = 3'b011;
    @(negedge clk); {btn_c, btn_b, btn_a} = 3'b000;
    checks++;
    if (buzzer !== 1'b1) begin
      errors++;
      $display("FAIL zerar_pre_buzzer: got %b expected 1", buzzer);
    end
    zerar = 1'b1;
    @(negedge clk);
    m0 = 0; m1 = 0;
    check_scores("zerar_alarm_scores", 0, 0);
    checks++;
    if ({buzzer, ocupado} !== 2'b00) begin
      errors++;
      $display("FAIL zerar_alarm_flags: got %b expected 00", {buzzer, ocupado});
    end
    btn_c = 1'b1;
    @(negedge clk); btn_c = 1'b0;
    @(negedge clk); zerar = 1'b0;
    repeat (3) @(negedge clk);
    check_scores("zerar_held_scores", 0, 0);
    checks++;
    if ({buzzer, ocupado} !== 2'b00) begin
      errors++;
      $display("FAIL zerar_held_flags: got %b expected 00", {buzzer, ocupado});
    end
  endtask

  task automatic test_async_reset;
    op(3'b100, 1'b0, 1'b1);
    @(negedge clk); chave_sub = 1'b0; mudar_time = 1'b0; btn_a = 1'b1;
    @(negedge clk); btn_a = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m0 = 0; m1 = 0;
    check_scores("async_scores", 0, 0);
    checks++;
    if ({buzzer, led, ocupado} !== 3'b000) begin
      errors++;
      $display("FAIL async_flags: got %b expected 000", {buzzer, led, ocupado});
    end
    btn_a = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_scores("held_btn_scores", 0, 0);
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL held_btn_busy: got %b expected 0", ocupado);
    end
    btn_a = 1'b0;
    @(negedge clk);
    op(3'b001, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_boundary();
    test_underflow();
    test_back_to_back();
    test_zerar_alarme();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
